// File: rtl/rv32i_mc_ctrl.sv
// rtl/rv32i_mc_ctrl.sv - multi-cycle control FSM for the RV32I core
//
// Purpose: sequences the datapath through IDLE/FETCH/DECODE/EXEC/MEM/WB and
// traps on illegal instructions or memory timeouts.
// Optional feature macro: RV32I_CTRL_PERF_EN adds cycle_cnt and instret.
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   start                       leave IDLE and begin fetching
//   opcode, funct3, funct7_5    instruction fields from the IR
//   alu_zero                    ALU result equals zero
//   imem_req / imem_ack         instruction fetch handshake
//   dmem_req, dmem_we / dmem_ack data access handshake (we: 1=store)
//   ir_we, pc_we, rf_we         IR, PC and register file write enables
//   alu_op, alu_src_imm         ALU operation and B-operand select
//   wb_sel_mem, branch_taken    writeback source and PC mux select
//   busy, trap, trap_cause      status (cause 01 illegal, 10 imem, 11 dmem)
//   cycle_cnt, instret          busy-cycle and retired-instruction counters
module rv32i_mc_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic [3:0] alu_op,
  output logic       alu_src_imm,
  output logic       wb_sel_mem,
  output logic       branch_taken,
  output logic       busy,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef RV32I_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [6:0] {
    R_TYPE      = 7'b0110011,
    I_TYPE_ALU  = 7'b0010011,
    I_TYPE_LOAD = 7'b0000011,
    S_TYPE      = 7'b0100011,
    B_TYPE      = 7'b1100011
  } instr_type_t;

  typedef enum logic [3:0] {
    ADD_OP = 4'd0, SUB_OP = 4'd1, AND_OP = 4'd2, OR_OP  = 4'd3,
    XOR_OP = 4'd4, SLL_OP = 4'd5, SRL_OP = 4'd6, SRA_OP = 4'd7,
    BEQ_OP = 4'd8
  } alu_op_t;

  state_t            r_state;
  logic [1:0]        r_cause;
  logic [CNTW-1:0]   r_cnt;
  logic              r_is_load;
  logic              r_is_store;
  logic              r_pc_we;
  logic              r_br_exec;

  state_t            w_next;
  logic [1:0]        w_cause;
  logic              w_legal;
  logic              w_arith_ok;
  alu_op_t           w_arith;
  alu_op_t           w_alu_op;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_branch;
  logic              w_imm;
  logic              w_timeout;

  // Instruction decode; only meaningful while r_state == S_DECODE.
  always_comb begin
    w_arith_ok = 1'b1;
    w_arith    = ADD_OP;
    case (funct3)
      3'b000:  w_arith = (opcode == R_TYPE && funct7_5) ? SUB_OP : ADD_OP;
      3'b111:  w_arith = AND_OP;
      3'b110:  w_arith = OR_OP;
      3'b100:  w_arith = XOR_OP;
      3'b001:  w_arith = SLL_OP;
      3'b101:  w_arith = funct7_5 ? SRA_OP : SRL_OP;
      default: w_arith_ok = 1'b0;
    endcase

    w_legal     = 1'b0;
    w_alu_op    = ADD_OP;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_imm       = 1'b0;
    case (opcode)
      R_TYPE: begin
        w_legal  = w_arith_ok;
        w_alu_op = w_arith;
      end
      I_TYPE_ALU: begin
        w_legal  = w_arith_ok;
        w_alu_op = w_arith;
        w_imm    = 1'b1;
      end
      I_TYPE_LOAD: begin
        w_legal   = (funct3 == 3'b010);
        w_is_load = 1'b1;
        w_imm     = 1'b1;
      end
      S_TYPE: begin
        w_legal    = (funct3 == 3'b010);
        w_is_store = 1'b1;
        w_imm      = 1'b1;
      end
      B_TYPE: begin
        w_legal     = (funct3 == 3'b000);
        w_is_branch = 1'b1;
        w_alu_op    = BEQ_OP;
      end
      default: ;
    endcase
  end

  // Last waiting cycle: an ack here still wins over the trap.
  assign w_timeout = (r_cnt == CNTW'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next  = r_state;
    w_cause = r_cause;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack) w_next = S_DECODE;
        else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_DECODE: begin
        if (w_legal) w_next = S_EXEC;
        else begin
          w_next  = S_TRAP;
          w_cause = 2'b01;
        end
      end
      S_EXEC: begin
        if (r_is_load || r_is_store) w_next = S_MEM;
        else if (r_br_exec)          w_next = S_FETCH;
        else                         w_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) w_next = r_is_store ? S_FETCH : S_WB;
        else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = 2'b11;
        end
      end
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each is a clean Moore
  // decode of the state being entered.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_cause     <= 2'b00;
      r_cnt       <= '0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_pc_we     <= 1'b0;
      r_br_exec   <= 1'b0;
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      rf_we       <= 1'b0;
      alu_op      <= 4'd0;
      alu_src_imm <= 1'b0;
      wb_sel_mem  <= 1'b0;
      busy        <= 1'b0;
      trap        <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      if (r_state == S_DECODE) begin
        r_is_load  <= w_is_load;
        r_is_store <= w_is_store;
      end
      if (w_next != r_state)                         r_cnt <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM) r_cnt <= r_cnt + 1'b1;
      imem_req    <= (w_next == S_FETCH);
      dmem_req    <= (w_next == S_MEM);
      dmem_we     <= (w_next == S_MEM) && r_is_store;
      rf_we       <= (w_next == S_WB);
      wb_sel_mem  <= (w_next == S_WB) && r_is_load;
      r_pc_we     <= ((w_next == S_EXEC) && w_is_branch) || (w_next == S_WB);
      r_br_exec   <= (w_next == S_EXEC) && w_is_branch;
      alu_op      <= (w_next == S_EXEC) ? w_alu_op : ADD_OP;
      alu_src_imm <= (w_next == S_EXEC) && w_imm;
      busy        <= (w_next != S_IDLE) && (w_next != S_TRAP);
      trap        <= (w_next == S_TRAP);
    end
  end

  assign ir_we        = (r_state == S_FETCH) && imem_ack;
  assign pc_we        = r_pc_we || ((r_state == S_MEM) && r_is_store && dmem_ack);
  assign branch_taken = r_br_exec && alu_zero;
  assign trap_cause   = r_cause;

`ifdef RV32I_CTRL_PERF_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cycle_cnt <= 32'd0;
      instret   <= 32'd0;
    end else begin
      if (busy)  cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we) instret   <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb/tb_rv32i_mc_ctrl.sv - randomized self-checking bench for rv32i_mc_ctrl
module tb_rv32i_mc_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       wb_sel_mem;
    logic       branch_taken;
    logic       busy;
    logic       trap;
    logic [1:0] cause;
  } ovec_t;

  logic       clk;
  logic       arst_n;
  logic       start;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero;
  logic       imem_req;
  logic       imem_ack;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;
  logic       ir_we;
  logic       pc_we;
  logic       rf_we;
  logic [3:0] alu_op;
  logic       alu_src_imm;
  logic       wb_sel_mem;
  logic       branch_taken;
  logic       busy;
  logic       trap;
  logic [1:0] trap_cause;
`ifdef RV32I_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret;
  int unsigned m_cyc;
  int unsigned m_inst;
`endif

  int n_checks;
  int n_fail;
  ovec_t obs;

  rv32i_mc_ctrl #(.MEM_TIMEOUT(15), .CNTW(4)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .wb_sel_mem(wb_sel_mem),
    .branch_taken(branch_taken), .busy(busy), .trap(trap), .trap_cause(trap_cause)
`ifdef RV32I_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_op,
                alu_src_imm, wb_sel_mem, branch_taken, busy, trap, trap_cause};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ovec_t v_trap(input logic [1:0] c);
    ovec_t e;
    e = '0;
    e.trap  = 1'b1;
    e.cause = c;
    return e;
  endfunction

  // One clock: drive inputs just after the edge, check on the falling edge.
  task automatic cyc(input logic ia, input logic da, input logic st, input logic z,
                     input ovec_t e, input string tag);
    @(posedge clk);
    #1;
    imem_ack = ia;
    dmem_ack = da;
    start    = st;
    alu_zero = z;
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
`ifdef RV32I_CTRL_PERF_EN
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("instret", instret, m_inst);
    if (e.busy)  m_cyc++;
    if (e.pc_we) m_inst++;
`endif
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference decode: instruction class, legality and expected ALU op.
  function automatic void model(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                                output int cls, output bit legal, output logic [3:0] aop);
    case (opc)
      7'b0110011: cls = 0;
      7'b0010011: cls = 1;
      7'b0000011: cls = 2;
      7'b0100011: cls = 3;
      7'b1100011: cls = 4;
      default:    cls = 5;
    endcase
    legal = 1'b0;
    aop   = 4'd0;
    if (cls <= 1) begin
      legal = !(f3 == 3'd2 || f3 == 3'd3);
      case (f3)
        3'd0: aop = (cls == 0 && f75) ? 4'd1 : 4'd0;
        3'd1: aop = 4'd5;
        3'd4: aop = 4'd4;
        3'd5: aop = f75 ? 4'd7 : 4'd6;
        3'd6: aop = 4'd3;
        3'd7: aop = 4'd2;
        default: aop = 4'd0;
      endcase
    end else if (cls <= 3) begin
      legal = (f3 == 3'd2);
    end else if (cls == 4) begin
      legal = (f3 == 3'd0);
      aop   = 4'd8;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    arst_n   = 1'b0;
    start    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("reset_outs", 32'(obs), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
`ifdef RV32I_CTRL_PERF_EN
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_instret", instret, 32'd0);
    m_cyc  = 0;
    m_inst = 0;
`endif
  endtask

  task automatic go();
    cyc(rb(), rb(), 1'b0, rb(), ovec_t'('0), "idle_hold");
    cyc(rb(), rb(), 1'b1, rb(), ovec_t'('0), "idle_start");
  endtask

  task automatic trap_tail(input logic [1:0] c);
    cyc(rb(), rb(), 1'b1, rb(), v_trap(c), "trap_entry");
    cyc(rb(), rb(), 1'b1, rb(), v_trap(c), "trap_sticky");
    cyc(rb(), rb(), 1'b1, rb(), v_trap(c), "trap_sticky");
  endtask

  // fw/mw: wait cycles before ack (>=15 means never). zsel 2 = random alu_zero.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                           input int fw, input int mw, input int zsel, output bit trapped);
    ovec_t e;
    int cls;
    bit legal;
    logic [3:0] aop;
    logic z;
    logic ack;
    trapped  = 1'b0;
    opcode   = opc;
    funct3   = f3;
    funct7_5 = f75;
    model(opc, f3, f75, cls, legal, aop);
    for (int w = 0; w <= fw && w < 15; w++) begin
      ack = (w == fw);
      e = '0;
      e.imem_req = 1'b1;
      e.busy     = 1'b1;
      e.ir_we    = ack;
      cyc(ack, rb(), rb(), rb(), e, "fetch");
    end
    if (fw >= 15) begin
      trap_tail(2'b10);
      trapped = 1'b1;
      return;
    end
    e = '0;
    e.busy = 1'b1;
    cyc(rb(), rb(), rb(), rb(), e, "decode");
    if (!legal) begin
      trap_tail(2'b01);
      trapped = 1'b1;
      return;
    end
    z = (zsel == 2) ? rb() : 1'(zsel);
    e = '0;
    e.busy         = 1'b1;
    e.alu_op       = aop;
    e.alu_src_imm  = (cls >= 1 && cls <= 3);
    e.pc_we        = (cls == 4);
    e.branch_taken = (cls == 4) && z;
    cyc(rb(), rb(), rb(), z, e, "exec");
    if (cls == 4) return;
    if (cls == 2 || cls == 3) begin
      for (int w = 0; w <= mw && w < 15; w++) begin
        ack = (w == mw);
        e = '0;
        e.dmem_req = 1'b1;
        e.dmem_we  = (cls == 3);
        e.pc_we    = (cls == 3) && ack;
        e.busy     = 1'b1;
        cyc(rb(), ack, rb(), rb(), e, "mem");
      end
      if (mw >= 15) begin
        trap_tail(2'b11);
        trapped = 1'b1;
        return;
      end
      if (cls == 3) return;
    end
    e = '0;
    e.busy       = 1'b1;
    e.rf_we      = 1'b1;
    e.pc_we      = 1'b1;
    e.wb_sel_mem = (cls == 2);
    cyc(rb(), rb(), rb(), rb(), e, "wb");
  endtask

  initial begin
    bit t;
    ovec_t e;
    logic [6:0] opc_tab [6];
    int k;
    logic [2:0] f3;
    n_checks = 0;
    n_fail   = 0;
    arst_n   = 1'b0;
    start    = 1'b0;
    opcode   = 7'd0;
    funct3   = 3'd0;
    funct7_5 = 1'b0;
    alu_zero = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    opc_tab  = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};

    do_reset();
    go();
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 2, t);   // add x3,x1,x2
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 2, t);   // lw, slow ack
    run_instr(7'b0100011, 3'b010, 1'b0, 1, 0, 2, t);   // sw
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1, t);   // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 0, t);   // beq not taken
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 2, t);   // sub
    run_instr(7'b0010011, 3'b101, 1'b1, 2, 0, 2, t);   // srai
    run_instr(7'b0110011, 3'b111, 1'b0, 14, 0, 2, t);  // ack on the 15th fetch cycle
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 14, 2, t);  // ack on the 15th mem cycle

    for (int i = 0; i < 80; i++) begin
      k  = $urandom_range(0, 5);
      f3 = 3'($urandom_range(0, 7));
      if (k >= 2 && k <= 4 && $urandom_range(0, 3) != 0) f3 = (k == 4) ? 3'd0 : 3'd2;
      run_instr(opc_tab[k], f3, rb(),
                ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3),
                $urandom_range(0, 3), 2, t);
      if (t) begin
        do_reset();
        go();
      end
    end

    do_reset();
    go();
    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 2, t);   // lui -> illegal
    check("lui_trapped", 32'(t), 32'd1);
    do_reset();
    go();
    run_instr(7'b0110011, 3'b010, 1'b0, 0, 0, 2, t);   // slt -> illegal
    do_reset();
    go();
    run_instr(7'b0110011, 3'b000, 1'b0, 15, 0, 2, t);  // imem timeout
    do_reset();
    go();
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 15, 2, t);  // dmem timeout

    do_reset();
    go();
    e = '0;
    e.imem_req = 1'b1;
    e.busy     = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, e, "fetch_pre_reset");
    #2;
    arst_n = 1'b0;
    #1;
    check("async_reset_req", 32'(imem_req), 32'd0);
    check("async_reset_outs", 32'(obs), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
`ifdef RV32I_CTRL_PERF_EN
    m_cyc  = 0;
    m_inst = 0;
`endif
    go();
    run_instr(7'b0010011, 3'b110, 1'b0, 0, 0, 2, t);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
